// File: rtl/obstacle_row_sequencer.sv
// Row-buffered obstacle scheduler: buffers generator rows and streams the visible rows once per frame.
// Optional STARVE_COUNT_EN adds a saturating count of frames that needed filler words.
module obstacle_row_sequencer #(
  parameter int DEPTH        = 8,
  parameter int VISIBLE_ROWS = 4,
  parameter int BLOCK_LENGTH = 128,
  parameter int SPEED        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            new_frame,
  input  logic                            game_over,
  input  logic [47:0]                     row_in,
  input  logic                            row_in_valid,
  output logic                            row_in_ready,
  output logic [15:0]                     obstacle,
  output logic                            obstacle_valid,
  output logic                            firstrow,
  output logic                            frame_done,
  output logic [$clog2(BLOCK_LENGTH)-1:0] block_progress,
  output logic [$clog2(DEPTH):0]          rows_available,
  output logic                            starved,
  output logic                            frame_overrun
`ifdef STARVE_COUNT_EN
  ,
  output logic [7:0]                      starve_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BLOCK_LENGTH);
  localparam int RW = $clog2(VISIBLE_ROWS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, ADVANCE} state_t;

  state_t        state;
  logic [47:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, snap, sel_count;
  logic [RW-1:0] row_idx, next_row;
  logic [1:0]    lane, next_lane;
  logic [47:0]   sel_row;
  logic [15:0]   lane_word, next_word;
  logic          next_starved;
  logic [BW:0]   sum;
  logic          push, pop, last_word;

  assign row_in_ready   = (count < CW'(DEPTH));
  assign rows_available = count;
  assign push           = row_in_valid && row_in_ready;
  assign sum            = {1'b0, block_progress} + (BW+1)'(SPEED);
  assign pop            = (state == ADVANCE) && !game_over &&
                          (sum >= (BW+1)'(BLOCK_LENGTH)) && (count != '0);
  assign last_word      = (row_idx == RW'(VISIBLE_ROWS - 1)) && (lane == 2'd2);

  // Precompute the word to be registered at the next edge; the row count used for
  // filler decisions is frozen at stream entry so late pushes cannot change a frame.
  always_comb begin
    next_row  = row_idx;
    next_lane = lane;
    if (state != STREAM) begin
      next_row  = '0;
      next_lane = '0;
    end else if (lane == 2'd2) begin
      next_row  = row_idx + RW'(1);
      next_lane = '0;
    end else begin
      next_lane = lane + 2'd1;
    end
    sel_count = (state == STREAM) ? snap : count;
    sel_row   = mem[rd_ptr + PW'(next_row)];
    case (next_lane)
      2'd0:    lane_word = sel_row[15:0];
      2'd1:    lane_word = sel_row[31:16];
      default: lane_word = sel_row[47:32];
    endcase
    next_starved = (CW'(next_row) >= sel_count);
    next_word    = next_starved ? {3'b000, next_lane, 11'd0}
                                : {lane_word[15:13], next_lane, lane_word[10:0]};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= row_in;
  end

  // Frame FSM plus buffer bookkeeping; pops only ever happen in ADVANCE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      snap           <= '0;
      row_idx        <= '0;
      lane           <= '0;
      obstacle       <= '0;
      obstacle_valid <= 1'b0;
      firstrow       <= 1'b0;
      starved        <= 1'b0;
      frame_done     <= 1'b0;
      block_progress <= '0;
      frame_overrun  <= 1'b0;
`ifdef STARVE_COUNT_EN
      starve_count   <= '0;
`endif
    end else begin
      if (new_frame && state != IDLE) frame_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (new_frame) begin
            state          <= STREAM;
            snap           <= count;
            row_idx        <= '0;
            lane           <= '0;
            obstacle       <= next_word;
            obstacle_valid <= 1'b1;
            firstrow       <= 1'b1;
            starved        <= next_starved;
          end
        end
        STREAM: begin
          if (last_word) begin
            state          <= ADVANCE;
            obstacle       <= '0;
            obstacle_valid <= 1'b0;
            firstrow       <= 1'b0;
            starved        <= 1'b0;
            frame_done     <= 1'b1;
          end else begin
            row_idx  <= next_row;
            lane     <= next_lane;
            obstacle <= next_word;
            firstrow <= (next_row == '0);
            starved  <= next_starved;
          end
        end
        ADVANCE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
          if (!game_over) begin
            if (sum >= (BW+1)'(BLOCK_LENGTH))
              block_progress <= BW'(sum - (BW+1)'(BLOCK_LENGTH));
            else
              block_progress <= BW'(sum);
          end
`ifdef STARVE_COUNT_EN
          if (snap < CW'(VISIBLE_ROWS) && starve_count != 8'hFF)
            starve_count <= starve_count + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: doc/obstacle_row_sequencer.md
Name: obstacle_row_sequencer

Overview:
Row-buffered scheduler between the obstacle generator and the game logic/collision datapath.
- Holds upcoming obstacle rows (3 lanes per row) in a circular buffer.
- Once per frame, streams the visible rows word-by-word as obstacle/obstacle_valid/firstrow.
- Tracks forward progress and retires the head row each time the player covers one block length.

Parameters:
DEPTH, 8, row buffer capacity in rows; power of two, ≥ VISIBLE_ROWS
VISIBLE_ROWS, 4, rows streamed per frame (row 0 = first row)
BLOCK_LENGTH, 128, score points per row; power of two
SPEED, 4, score points advanced per frame; must divide BLOCK_LENGTH

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
new_frame  input  1  single-cycle frame strobe
game_over  input  1  freezes progress/pops while high
row_in  input  48  generator row; lane L word = row_in[16*L+15:16*L]
row_in_valid  input  1  generator row valid
row_in_ready  output  1  buffer can accept a row
obstacle  output  16  streamed word: [15:13] type, [12:11] lane, [10:0] payload
obstacle_valid  output  1  obstacle word valid this cycle
firstrow  output  1  high when streamed word belongs to row 0
frame_done  output  1  one-cycle pulse, streaming for this frame finished
block_progress  output  $clog2(BLOCK_LENGTH)  score points into current head row
rows_available  output  $clog2(DEPTH)+1  rows currently buffered
starved  output  1  current streamed word is filler (buffer short)
frame_overrun  output  1  sticky; new_frame arrived while not IDLE

Behaviour:
Reset values: all outputs 0 except row_in_ready=1. Pointers, count and progress are 0; FSM is IDLE. Reset mid-stream aborts immediately with no frame_done.

Write side:
- row_in_ready = (count < DEPTH).
- Push on row_in_valid && row_in_ready, accepted in any FSM state.

FSM states: IDLE, STREAM, ADVANCE.
- IDLE: new_frame → STREAM on the next cycle. Row index r=0, lane l=0.
- STREAM: one word per cycle, obstacle_valid=1, order row0 lanes 0,1,2, then row1, and so on. The first word appears the cycle after new_frame; VISIBLE_ROWS*3 cycles total.
  - obstacle[15:13] and [10:0] come from the buffered row's lane-l word. obstacle[12:11] is forced to l, regardless of stored bits.
  - firstrow = (r==0).
  - If r ≥ count as sampled at STREAM entry, emit filler {3'b000, l, 11'd0} with starved=1.
  - After the last word → ADVANCE, with frame_done pulsed in that same ADVANCE cycle.
- ADVANCE (1 cycle): if !game_over, sum = block_progress + SPEED.
  - sum ≥ BLOCK_LENGTH: progress = sum − BLOCK_LENGTH, and the head row is popped if count>0.
  - Otherwise progress = sum.
  - If game_over, progress and buffer are unchanged.
  - Next state IDLE.

Boundary and arithmetic rules:
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Pop with count=0: progress still wraps, no pop, count stays 0.
- Push when full: not accepted (ready=0).
- new_frame while in STREAM or ADVANCE: ignored, frame_overrun set to 1 until rst.
- The buffer contents streamed in a frame are stable: pushes only append behind the sampled count, so they do not alter words of that frame.
- Outputs obstacle/firstrow/starved are 0 when obstacle_valid=0.

Optional Feature:
Macro STARVE_COUNT_EN.
- With it: adds output starve_count [7:0]. It increments, saturating at 255, in each ADVANCE cycle where the just-finished frame emitted at least one filler word; reset 0.
- Without it: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, push rows A..D (lane words 0x2000|n), pulse new_frame → 12 valid words starting next cycle, lanes 0,1,2 repeating, firstrow=1 only for the first 3, frame_done pulse after word 12.
2. Push 2 rows only, new_frame → words 7..12 are filler 0x0000/0x0800/0x1000 with starved=1; words 1..6 starved=0.
3. 32 frames, SPEED=4, BLOCK_LENGTH=128, 5 rows buffered → after frame 32 block_progress=0, rows_available=4; after frame 31 progress=124, rows_available=5.
4. Hold game_over=1 for 10 frames → streaming continues identically each frame, block_progress and rows_available unchanged.
5. Fill to 8 rows → row_in_ready=0, 9th row rejected. At a popping ADVANCE with row_in_valid high, ready rises and the push plus pop leave count=8.
6. new_frame pulsed again 3 cycles into STREAM → stream completes normally with 12 words, frame_overrun=1 and stays 1; rst mid-stream → obstacle_valid=0 next cycle, no frame_done.
